// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and bitwise helper functions.
// Used by the compression core and the message scheduler.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

endpackage

// File: rtl/func_Ma.sv
// SHA-256 majority function: each output bit is the majority of a, b, c.
module func_Ma (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);
  assign y = (a & b) ^ (a & c) ^ (b & c);
endmodule

// File: rtl/sha256_msg_sched.sv
// 16-word message window; window[0] is always the current round's W[t].
// Each shift appends the expanded word W[t+16].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [511:0] block_in,
  input  logic         shift,
  output logic [31:0]  w_t
);

  logic [0:15][31:0] win_q, win_d;
  logic [31:0]       w_next;

  assign w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  assign w_t    = win_q[0];

  always_comb begin
    win_d = win_q;
    if (load) begin
      win_d = block_in;
    end else if (shift) begin
      win_d = {win_q[1:15], w_next};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, 64 rounds plus a
// final feed-forward cycle per block.
module sha256_compress_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic              done_q, done_d;
  logic [0:7][31:0]  hash_q, hash_d;
  logic [0:7][31:0]  work_q, work_d;
  logic [0:7][31:0]  hsave_q, hsave_d;

  logic              load, shift;
  logic [31:0]       w_t, maj, t1, t2;

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .block_in (block_in),
    .shift    (shift),
    .w_t      (w_t)
  );

  func_Ma u_ma (
    .a (work_q[0]),
    .b (work_q[1]),
    .c (work_q[2]),
    .y (maj)
  );

  assign t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
            + K[t_q] + w_t;
  assign t2 = big_sigma0(work_q[0]) + maj;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    hash_d  = hash_q;
    work_d  = work_q;
    hsave_d = hsave_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          work_d  = hash_in;
          hsave_d = hash_in;
          t_d     = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        shift  = 1'b1;
        work_d = {t1 + t2, work_q[0], work_q[1], work_q[2],
                  work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
        t_d    = t_q + 6'd1;
        if (t_q == 6'd63) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[i] = hsave_q[i] + work_q[i];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
    end
  end

  // Working variables are only meaningful while a block is in flight.
  always_ff @(posedge clk) begin
    work_q  <= work_d;
    hsave_q <= hsave_d;
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core using known SHA-256 digests.
module tb_sha256_compress_core;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int checks = 0;
  int errors = 0;

  sha256_compress_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  localparam logic [255:0] IV_W   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_2 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  vec_t vecs [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Launches a block and returns in the cycle done is high (or on timeout).
  task automatic run(input logic [511:0] blk, input logic [255:0] hin, output int lat);
    block_in = blk;
    hash_in  = hin;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    block_in = ~blk;
    hash_in  = ~hin;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [255:0] got;

    vecs[0] = '{"abc",   BLK_ABC,   IV_W, DIG_ABC};
    vecs[1] = '{"empty", BLK_EMPTY, IV_W, DIG_EMPTY};

    rst = 1'b1; start = 1'b0; block_in = '0; hash_in = '0;
    tick(); tick();
    check("reset_busy", {255'h0, busy}, 256'h0);
    check("reset_done", {255'h0, done}, 256'h0);
    check("reset_hash", hash_out, 256'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 2; i++) begin
      run(vecs[i].blk, vecs[i].hin, lat);
      check({vecs[i].name, "_latency"}, 256'(lat), 256'd65);
      check({vecs[i].name, "_digest"}, hash_out, vecs[i].exp);
      check({vecs[i].name, "_busy_at_done"}, {255'h0, busy}, 256'h0);
      tick();
      check({vecs[i].name, "_done_pulse"}, {255'h0, done}, 256'h0);
      check({vecs[i].name, "_hold"}, hash_out, vecs[i].exp);
      tick();
    end

    // Two-block message, second block launched in the done cycle of the first.
    run(BLK_2A, IV_W, lat);
    check("two_block_first_latency", 256'(lat), 256'd65);
    got = hash_out;
    block_in = BLK_2B;
    hash_in  = got;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    block_in = '0;
    hash_in  = '0;
    check("two_block_busy", {255'h0, busy}, 256'h1);
    wait_done(lat);
    check("two_block_second_latency", 256'(lat), 256'd65);
    check("two_block_digest", hash_out, DIG_2);
    tick(); tick();

    // start during rounds is ignored.
    block_in = BLK_ABC; hash_in = IV_W; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    block_in = BLK_EMPTY; hash_in = ~IV_W; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    got = '0;
    for (int c = 0; c < 80; c++) begin
      if (done === 1'b1) begin
        ndone++;
        got = hash_out;
      end
      tick();
    end
    check("ignored_start_done_count", 256'(ndone), 256'd1);
    check("ignored_start_digest", got, DIG_ABC);

    // Reset mid-block discards it.
    block_in = BLK_EMPTY; hash_in = IV_W; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("midreset_busy_before", {255'h0, busy}, 256'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_busy", {255'h0, busy}, 256'h0);
    check("midreset_done", {255'h0, done}, 256'h0);
    check("midreset_hash", hash_out, 256'h0);
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("midreset_no_done", 256'(ndone), 256'd0);
    run(BLK_ABC, IV_W, lat);
    check("post_reset_latency", 256'(lat), 256'd65);
    check("post_reset_digest", hash_out, DIG_ABC);
    tick();

    // rst and start together: reset wins.
    rst = 1'b1; start = 1'b1; block_in = BLK_ABC; hash_in = IV_W;
    tick();
    check("rst_start_busy", {255'h0, busy}, 256'h0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_busy_after", {255'h0, busy}, 256'h0);
    check("rst_start_hash", hash_out, 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
